// File: rtl/fp_div_nr_seq.sv
// ---------------------------------------------------------------------------
// fp_div_nr_seq
//
// Sequencer for single-precision division q = n / d by Newton-Raphson
// refinement of a reciprocal seed. It uses one shared external FMA
// unit (a*b + c).
//
//   f0      = seed_f0(d)               from the combinational reciprocal lookup
//   repeat ITERS times:
//     e     = 2 - d*f                  FMA(-d, f, 2.0)
//     f     = f*e                      FMA(f, e, 0)
//   q       = n*f                      FMA(n, f, 0)
//
// IEEE special operands (NaN, zero, infinity) are resolved locally and
// issue no FMA traffic. No rounding fix-up is applied to the final quotient.
//
// Parameters
//   ITERS           number of NR iterations (1..7), two FMA ops each
//   TIMEOUT_CYCLES  watchdog limit per ISSUE/WAIT state (watchdog build only)
//
// Optional feature (compile-time macro): FP_DIV_TIMEOUT_EN
//   When this macro is defined, a watchdog counts cycles spent in each
//   ISSUE/WAIT state. If it expires, the operation ends with result = qNaN
//   and err = 1. When it is undefined, the block waits indefinitely and
//   err is tied to 0.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   start, op_n, op_d           request pulse (sampled in IDLE) and operands
//   busy, done, result, err     status, one-cycle completion pulse, quotient,
//                               watchdog abort flag
//   seed_d / seed_f0            latched denominator to, and seed from, the
//                               reciprocal lookup
//   fma_req_valid/ready         FMA request handshake
//   fma_a, fma_b, fma_c         FMA operands, held stable while valid
//   fma_resp_valid/data         FMA result return (in order, one outstanding)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fp_div_nr_seq #(
  parameter int ITERS          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_n,
  input  logic [31:0] op_d,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [31:0] seed_d,
  input  logic [31:0] seed_f0,
  output logic        fma_req_valid,
  input  logic        fma_req_ready,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  input  logic        fma_resp_valid,
  input  logic [31:0] fma_resp_data
);

  if (ITERS < 1 || ITERS > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fp_div_nr_seq: ITERS must be 1..7 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_TWO  = 32'h4000_0000;
  localparam logic [2:0]  ITERS_L = 3'(ITERS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEED,
    S_ERR_ISSUE,
    S_ERR_WAIT,
    S_REF_ISSUE,
    S_REF_WAIT,
    S_QUO_ISSUE,
    S_QUO_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [31:0] result_q, result_d;
  logic [31:0] d_q, d_d;
  // Datapath registers below carry no reset; they are always written
  // before they are read in any operation.
  logic [31:0] n_q, n_d;
  logic [31:0] f_q, f_d;
  logic [31:0] e_q, e_d;

`ifdef FP_DIV_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_state;
`endif

  // ------------------------------------------------------------------------
  // Operand classification on the latched operands
  // ------------------------------------------------------------------------
  logic        n_nan, d_nan, n_inf, d_inf, n_zero, d_zero;
  logic        q_sign;
  logic        special;
  logic [31:0] special_res;

  always_comb begin
    // The zero test ignores the sign bit, so -0 counts as zero.
    // Denormals are treated as ordinary nonzero values.
    n_nan  = (n_q[30:23] == 8'hFF) && (n_q[22:0] != 23'd0);
    d_nan  = (d_q[30:23] == 8'hFF) && (d_q[22:0] != 23'd0);
    n_inf  = (n_q[30:23] == 8'hFF) && (n_q[22:0] == 23'd0);
    d_inf  = (d_q[30:23] == 8'hFF) && (d_q[22:0] == 23'd0);
    n_zero = (n_q[30:0] == 31'd0);
    d_zero = (d_q[30:0] == 31'd0);
    q_sign = n_q[31] ^ d_q[31];

    special     = 1'b1;
    special_res = QNAN;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      special_res = QNAN;
    end else if (d_zero) begin
      special_res = {q_sign, 8'hFF, 23'd0};
    end else if (d_inf) begin
      special_res = {q_sign, 31'd0};
    end else if (n_zero) begin
      special_res = {q_sign, 31'd0};
    end else if (n_inf) begin
      special_res = {q_sign, 8'hFF, 23'd0};
    end else begin
      special     = 1'b0;
      special_res = 32'd0;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state, datapath capture and FMA request generation
  // ------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    iter_d        = iter_q;
    result_d      = result_q;
    n_d           = n_q;
    d_d           = d_q;
    f_d           = f_q;
    e_d           = e_q;
    fma_req_valid = 1'b0;
    fma_a         = 32'd0;
    fma_b         = 32'd0;
    fma_c         = 32'd0;
`ifdef FP_DIV_TIMEOUT_EN
    err_d         = err_q;
    tmo_d         = '0;
    tmo_state     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = op_n;
          d_d     = op_d;
          state_d = S_SEED;
        end
      end

      S_SEED: begin
        f_d = seed_f0;
        if (special) begin
          result_d = special_res;
          state_d  = S_DONE;
        end else begin
          iter_d  = 3'd0;
          state_d = S_ERR_ISSUE;
        end
      end

      // e = 2 - d*f. The FMA unit has no negate input, so the product is
      // negated by flipping the sign of d.
      S_ERR_ISSUE: begin
        fma_req_valid = 1'b1;
        fma_a         = {~d_q[31], d_q[30:0]};
        fma_b         = f_q;
        fma_c         = FP_TWO;
        if (fma_req_ready) state_d = S_ERR_WAIT;
      end

      S_ERR_WAIT: begin
        if (fma_resp_valid) begin
          e_d     = fma_resp_data;
          state_d = S_REF_ISSUE;
        end
      end

      S_REF_ISSUE: begin
        fma_req_valid = 1'b1;
        fma_a         = f_q;
        fma_b         = e_q;
        fma_c         = 32'd0;
        if (fma_req_ready) state_d = S_REF_WAIT;
      end

      S_REF_WAIT: begin
        if (fma_resp_valid) begin
          f_d    = fma_resp_data;
          iter_d = iter_q + 3'd1;
          if (iter_q + 3'd1 == ITERS_L) state_d = S_QUO_ISSUE;
          else                          state_d = S_ERR_ISSUE;
        end
      end

      S_QUO_ISSUE: begin
        fma_req_valid = 1'b1;
        fma_a         = n_q;
        fma_b         = f_q;
        fma_c         = 32'd0;
        if (fma_req_ready) state_d = S_QUO_WAIT;
      end

      S_QUO_WAIT: begin
        if (fma_resp_valid) begin
          result_d = fma_resp_data;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef FP_DIV_TIMEOUT_EN
    // The watchdog counts cycles spent in one ISSUE/WAIT state without
    // progress. When it expires, the operation is forced to DONE with a
    // qNaN result. Leaving the issue state drops fma_req_valid on the next
    // cycle. Keeping valid independent of ready in the abort cycle avoids a
    // combinational ready->valid path.
    tmo_state = (state_q == S_ERR_ISSUE) || (state_q == S_ERR_WAIT) ||
                (state_q == S_REF_ISSUE) || (state_q == S_REF_WAIT) ||
                (state_q == S_QUO_ISSUE) || (state_q == S_QUO_WAIT);
    if (state_q == S_DONE) err_d = 1'b0;
    if (tmo_state && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        state_d  = S_DONE;
        result_d = QNAN;
        err_d    = 1'b1;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      iter_q   <= 3'd0;
      result_q <= 32'd0;
      d_q      <= 32'd0;
`ifdef FP_DIV_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      d_q      <= d_d;
`ifdef FP_DIV_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    n_q <= n_d;
    f_q <= f_d;
    e_q <= e_d;
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign seed_d = d_q;
`ifdef FP_DIV_TIMEOUT_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule
